pdm_multi: RTL

Multi-channel pulse modulator. It drives CHANNELS independent 1-bit outputs, each selectable between first-order pulse density modulation (sigma-delta) and counter-based pulse width modulation. Duty and mode writes go to shadow registers and take effect only at a shared frame boundary, so outputs never glitch mid-frame. The block sits behind the peripheral register bus and drives LED dimming and analog-filter DAC pins.

---
 rtl/pdm_multi.sv | 117 +++++++++++
 1 files changed

// File: rtl/pdm_multi.sv
// Multi-channel PDM/PWM modulator. A shared frame counter gates shadow-to-active
// duty/mode transfers so that every channel changes only on a frame boundary.

module pdm_multi_lane #(
    parameter int DUTY_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic                 wr_i,
    input  logic [DUTY_BITS-1:0] cnt_i,
    input  logic [DUTY_BITS-1:0] wr_duty_i,
    input  logic                 wr_mode_i,
    output logic                 pdm_o
);
    localparam logic [DUTY_BITS:0] M = {1'b0, {DUTY_BITS{1'b1}}};

    logic [DUTY_BITS-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
    logic                 sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [DUTY_BITS:0]   acc_q, acc_d;
    logic                 pdm_q, pdm_d;

    always_comb begin
        sh_duty_d  = wr_i ? wr_duty_i : sh_duty_q;
        sh_mode_d  = wr_i ? wr_mode_i : sh_mode_q;
        // Loading from the _d side forwards a write landing on the load edge.
        act_duty_d = load_i ? sh_duty_d : act_duty_q;
        act_mode_d = load_i ? sh_mode_d : act_mode_q;
        acc_d      = acc_q;
        pdm_d      = 1'b0;
        if (!en_i) begin
            acc_d = '0;
        end else if (act_mode_q) begin
            pdm_d = (cnt_i < act_duty_q);
        end else if (acc_q >= M) begin
            acc_d = acc_q - M + {1'b0, act_duty_q};
            pdm_d = 1'b1;
        end else begin
            acc_d = acc_q + {1'b0, act_duty_q};
        end
        if (act_mode_d != act_mode_q)
            acc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_duty_q  <= '0;
            sh_mode_q  <= 1'b0;
            act_duty_q <= '0;
            act_mode_q <= 1'b0;
            acc_q      <= '0;
            pdm_q      <= 1'b0;
        end else begin
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            acc_q      <= acc_d;
            pdm_q      <= pdm_d;
        end
    end

    assign pdm_o = pdm_q;
endmodule

module pdm_multi #(
    parameter int CHANNELS  = 4,
    parameter int DUTY_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         en_i,
    input  logic                        wr_en_i,
    input  logic [$clog2(CHANNELS)-1:0] wr_chan_i,
    input  logic [DUTY_BITS-1:0]        wr_duty_i,
    input  logic                        wr_mode_i,
    output logic [CHANNELS-1:0]         pdm_o,
    output logic                        frame_o
);
    localparam int CW = $clog2(CHANNELS);
    localparam logic [DUTY_BITS-1:0] LAST = {{(DUTY_BITS-1){1'b1}}, 1'b0};

    logic [DUTY_BITS-1:0] cnt_q, cnt_d;
    logic                 frame_q;
    logic                 load;

    assign load  = (cnt_q == LAST);
    assign cnt_d = load ? '0 : cnt_q + DUTY_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= (cnt_q == '0);
        end
    end

    assign frame_o = frame_q;

    // Out-of-range channel numbers match no lane, so such writes drop naturally.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pdm_multi_lane #(.DUTY_BITS(DUTY_BITS)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en_i[g]),
            .load_i    (load),
            .wr_i      (wr_en_i && (wr_chan_i == CW'(g))),
            .cnt_i     (cnt_q),
            .wr_duty_i (wr_duty_i),
            .wr_mode_i (wr_mode_i),
            .pdm_o     (pdm_o[g])
        );
    end
endmodule
